excp_ctrl_seq: RTL and testbench



---
 rtl/excp_pkg.sv | 32 +++
 rtl/excp_prio_enc.sv | 32 +++
 rtl/excp_ctrl_seq.sv | 219 +++++++++++++++++++++
 tb/tb_excp_ctrl_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/excp_pkg.sv
// -----------------------------------------------------------------------------
// excp_pkg
// Shared definitions for the exception sequencer:
//   - state_t      : sequencer state encoding (IDLE/SAVE/WAIT/LOAD, 2 bits)
//   - CAUSE_*      : cause indices; a lower index means a higher priority
//   - VEC_BASE_DEFAULT : byte address of the cause-0 handler vector
//   - CNT_WIDTH    : width of the memory wait counter (MEM_WAIT is 1..15)
//   - cause_width(): width of a cause index, never less than one bit
// No ports (package).
// -----------------------------------------------------------------------------
package excp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SAVE = 2'd1,
      WAIT = 2'd2,
      LOAD = 2'd3
   } state_t;

   localparam int CAUSE_OPCODE     = 0;
   localparam int CAUSE_OVF        = 1;
   localparam int CAUSE_DIV0       = 2;

   localparam int VEC_BASE_DEFAULT = 253;

   localparam int CNT_WIDTH        = 4;

   function automatic int cause_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/excp_prio_enc.sv
// -----------------------------------------------------------------------------
// excp_prio_enc
// Parametrised priority encoder. Reports the lowest set bit of req, since
// index 0 is the highest-priority exception source.
// Ports:
//   req   in  [N-1:0]   request vector
//   idx   out [IW-1:0]  index of the lowest set bit (0 when none set)
//   valid out 1         at least one bit of req is set
// -----------------------------------------------------------------------------
module excp_prio_enc
   import excp_pkg::*;
#(
   parameter  int N  = 3,
   localparam int IW = cause_width(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      idx   = '0;
      valid = |req;
      // Scan from the top down so the lowest set index is the last to win.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/excp_ctrl_seq.sv
// -----------------------------------------------------------------------------
// excp_ctrl_seq
// Exception sequencer for the multicycle MIPS core. On an exception request it
// saves EPC = PC - 4, reads a one-byte handler vector at VEC_BASE + cause and
// loads PC with that byte zero-extended. Latency from the request edge to the
// PC load is MEM_WAIT + 2 cycles.
//
// Optional feature macro: EXCP_NEST_EN
//   defined   : requests arriving while busy (and same-cycle lower-priority
//               losers) are held in a pending register and serviced back to
//               back, chaining LOAD straight into SAVE.
//   undefined : such requests are dropped.
//
// Ports:
//   clk         in  1           system clock, rising edge
//   reset       in  1           synchronous active-high reset, dominates all
//   excp_req    in  NUM_CAUSES  one bit per cause, level sampled
//   pc_in       in  PC_WIDTH    current (already incremented) PC
//   mem_data    in  8           memory read byte
//   mem_addr    out PC_WIDTH    vector address, 0 when not reading
//   mem_rd      out 1           vector read in progress
//   epc_out     out PC_WIDTH    captured PC - 4
//   epc_write   out 1           one-cycle EPC load strobe
//   pc_out      out PC_WIDTH    zero-extended mem_data during LOAD
//   pc_write    out 1           one-cycle PC load strobe
//   busy        out 1           high in every state except IDLE
//   done        out 1           one-cycle pulse with pc_write
//   cause_code  out CW          index of the last serviced cause (sticky)
// -----------------------------------------------------------------------------
module excp_ctrl_seq
   import excp_pkg::*;
#(
   parameter  int NUM_CAUSES = 3,
   parameter  int MEM_WAIT   = 2,
   parameter  int VEC_BASE   = VEC_BASE_DEFAULT,
   parameter  int PC_WIDTH   = 32,
   localparam int CW         = cause_width(NUM_CAUSES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CAUSES-1:0] excp_req,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic [7:0]            mem_data,
   output logic [PC_WIDTH-1:0]   mem_addr,
   output logic                  mem_rd,
   output logic [PC_WIDTH-1:0]   epc_out,
   output logic                  epc_write,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic                  pc_write,
   output logic                  busy,
   output logic                  done,
   output logic [CW-1:0]         cause_code
);

   state_t                 state_reg,     state_next;
   logic [CW-1:0]          cause_reg,     cause_next;
   logic [PC_WIDTH-1:0]    pc_cap_reg,    pc_cap_next;
   logic                   epc_valid_reg, epc_valid_next;
   logic [CNT_WIDTH-1:0]   cnt_reg,       cnt_next;

   logic [NUM_CAUSES-1:0]  enc_in;
   logic [CW-1:0]          enc_idx;
   logic                   enc_valid;
   logic [PC_WIDTH-1:0]    vec_addr;

`ifdef EXCP_NEST_EN
   logic [NUM_CAUSES-1:0]  pend_reg, pend_next;
   logic [NUM_CAUSES-1:0]  win_mask;
`endif

   // ---------------------------------------------------------------------
   // Single shared priority encoder: looks at the live request in IDLE and,
   // when nesting is enabled, at pending plus live requests otherwise.
   // ---------------------------------------------------------------------
`ifdef EXCP_NEST_EN
   assign enc_in   = (state_reg == IDLE) ? excp_req : (pend_reg | excp_req);
   assign win_mask = NUM_CAUSES'(1) << enc_idx;
`else
   assign enc_in   = excp_req;
`endif

   excp_prio_enc #(
      .N     (NUM_CAUSES)
   ) u_prio_enc (
      .req   (enc_in),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   assign vec_addr = PC_WIDTH'(VEC_BASE) + PC_WIDTH'(cause_reg);

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cause_reg     <= '0;
         pc_cap_reg    <= '0;
         epc_valid_reg <= 1'b0;
         cnt_reg       <= '0;
`ifdef EXCP_NEST_EN
         pend_reg      <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         cause_reg     <= cause_next;
         pc_cap_reg    <= pc_cap_next;
         epc_valid_reg <= epc_valid_next;
         cnt_reg       <= cnt_next;
`ifdef EXCP_NEST_EN
         pend_reg      <= pend_next;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      cause_next     = cause_reg;
      pc_cap_next    = pc_cap_reg;
      epc_valid_next = epc_valid_reg;
      cnt_next       = cnt_reg;
`ifdef EXCP_NEST_EN
      pend_next      = pend_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (enc_valid) begin
               state_next  = SAVE;
               cause_next  = enc_idx;
               pc_cap_next = pc_in;
`ifdef EXCP_NEST_EN
               // Lower-priority bits raised alongside the winner wait their turn.
               pend_next   = pend_reg | (excp_req & ~win_mask);
`endif
            end
         end

         SAVE: begin
            epc_valid_next = 1'b1;
            cnt_next       = CNT_WIDTH'(MEM_WAIT);
            state_next     = WAIT;
`ifdef EXCP_NEST_EN
            pend_next      = pend_reg | excp_req;
`endif
         end

         WAIT: begin
            cnt_next = cnt_reg - 1'b1;
            // "<= 1" rather than "== 1" so an out-of-range zero cannot stall here.
            if (cnt_reg <= CNT_WIDTH'(1)) begin
               state_next = LOAD;
            end
`ifdef EXCP_NEST_EN
            pend_next = pend_reg | excp_req;
`endif
         end

         LOAD: begin
            state_next = IDLE;
`ifdef EXCP_NEST_EN
            if (enc_valid) begin
               // Chain into the next handler; its EPC is the handler address
               // being loaded right now.
               state_next  = SAVE;
               cause_next  = enc_idx;
               pc_cap_next = PC_WIDTH'(mem_data);
               pend_next   = enc_in & ~win_mask;
            end
`endif
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Moore outputs; pc_out alone follows mem_data combinationally in LOAD.
   // ---------------------------------------------------------------------
   always_comb begin
      mem_addr   = '0;
      mem_rd     = 1'b0;
      epc_write  = 1'b0;
      pc_out     = '0;
      pc_write   = 1'b0;
      done       = 1'b0;
      busy       = (state_reg != IDLE);
      cause_code = cause_reg;
      // epc_out holds between sequences; it reads 0 until the first SAVE.
      epc_out    = epc_valid_reg ? (pc_cap_reg - PC_WIDTH'(4)) : '0;

      case (state_reg)
         SAVE: begin
            epc_write = 1'b1;
            epc_out   = pc_cap_reg - PC_WIDTH'(4);
         end
         WAIT: begin
            mem_rd   = 1'b1;
            mem_addr = vec_addr;
         end
         LOAD: begin
            mem_rd   = 1'b1;
            mem_addr = vec_addr;
            pc_write = 1'b1;
            done     = 1'b1;
            pc_out   = PC_WIDTH'(mem_data);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_excp_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_excp_ctrl_seq
// Directed bench for excp_ctrl_seq. Two instances: dut_a (MEM_WAIT = 2) and
// dut_b (MEM_WAIT = 5). Expected sequences are pushed to a scoreboard queue
// when a request is driven and popped when the selected DUT runs it.
// Build with EXCP_NEST_EN defined to exercise back-to-back servicing.
// -----------------------------------------------------------------------------
module tb_excp_ctrl_seq;
   import excp_pkg::*;

   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    req_a = '0;
   logic [2:0]    req_b = '0;
   logic [PW-1:0] pc_in = '0;
   logic [7:0]    mem_data = '0;

   logic [PW-1:0] a_mem_addr, a_epc_out, a_pc_out;
   logic          a_mem_rd, a_epc_write, a_pc_write, a_busy, a_done;
   logic [1:0]    a_cause;
   logic [PW-1:0] b_mem_addr, b_epc_out, b_pc_out;
   logic          b_mem_rd, b_epc_write, b_pc_write, b_busy, b_done;
   logic [1:0]    b_cause;

   always #5 clk = ~clk;

   excp_ctrl_seq #(
      .NUM_CAUSES (3),
      .MEM_WAIT   (2),
      .VEC_BASE   (253),
      .PC_WIDTH   (PW)
   ) dut_a (
      .clk        (clk),
      .reset      (reset),
      .excp_req   (req_a),
      .pc_in      (pc_in),
      .mem_data   (mem_data),
      .mem_addr   (a_mem_addr),
      .mem_rd     (a_mem_rd),
      .epc_out    (a_epc_out),
      .epc_write  (a_epc_write),
      .pc_out     (a_pc_out),
      .pc_write   (a_pc_write),
      .busy       (a_busy),
      .done       (a_done),
      .cause_code (a_cause)
   );

   excp_ctrl_seq #(
      .NUM_CAUSES (3),
      .MEM_WAIT   (5),
      .VEC_BASE   (253),
      .PC_WIDTH   (PW)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .excp_req   (req_b),
      .pc_in      (pc_in),
      .mem_data   (mem_data),
      .mem_addr   (b_mem_addr),
      .mem_rd     (b_mem_rd),
      .epc_out    (b_epc_out),
      .epc_write  (b_epc_write),
      .pc_out     (b_pc_out),
      .pc_write   (b_pc_write),
      .busy       (b_busy),
      .done       (b_done),
      .cause_code (b_cause)
   );

   // Observation mux onto the DUT under test.
   logic          sel = 1'b0;
   logic [PW-1:0] o_mem_addr, o_epc_out, o_pc_out;
   logic          o_mem_rd, o_epc_write, o_pc_write, o_busy, o_done;
   logic [1:0]    o_cause;

   always_comb begin
      o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
      o_mem_rd    = sel ? b_mem_rd    : a_mem_rd;
      o_epc_out   = sel ? b_epc_out   : a_epc_out;
      o_epc_write = sel ? b_epc_write : a_epc_write;
      o_pc_out    = sel ? b_pc_out    : a_pc_out;
      o_pc_write  = sel ? b_pc_write  : a_pc_write;
      o_busy      = sel ? b_busy      : a_busy;
      o_done      = sel ? b_done      : a_done;
      o_cause     = sel ? b_cause     : a_cause;
   end

   typedef struct {
      logic [31:0] epc;
      logic [31:0] addr;
      logic [1:0]  cause;
      logic [7:0]  data;
      int          lat;
      int          inj_cyc;
      logic [2:0]  inj;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   last_cause = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] v);
      if (sel) req_b = v;
      else     req_a = v;
   endtask

   task automatic request(input logic [2:0] r, input logic [31:0] pc);
      pc_in = pc;
      set_req(r);
   endtask

   task automatic push(input logic [31:0] epc, input logic [31:0] addr, input int cause,
                       input logic [7:0] data, input int lat, input int inj_cyc,
                       input logic [2:0] inj);
      exp_t e;
      e.epc = epc; e.addr = addr; e.cause = 2'(cause); e.data = data;
      e.lat = lat; e.inj_cyc = inj_cyc; e.inj = inj;
      sb.push_back(e);
   endtask

   // Runs one sequence on the selected DUT and checks it against the oldest
   // scoreboard entry. Returns positioned 1 time unit after the LOAD edge.
   task automatic monitor();
      exp_t e;
      int   rd   = 0;
      bit   seen = 1'b0;
      e = sb.pop_front();
      for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
         step();
         if (cyc == 1) begin
            set_req(3'b000);
            mem_data = e.data;
         end
         if (e.inj_cyc != 0 && cyc == e.inj_cyc)     set_req(e.inj);
         if (e.inj_cyc != 0 && cyc == e.inj_cyc + 1) set_req(3'b000);
         chk("busy", o_busy, 1);
         if (o_epc_write) begin
            chk("epc_latency", cyc, 1);
            chk("epc_out", o_epc_out, e.epc);
            chk("cause_code", o_cause, e.cause);
         end
         if (o_mem_rd) begin
            chk("mem_addr", o_mem_addr, e.addr);
            if (!o_pc_write) rd++;
         end
         if (o_pc_write) begin
            chk("pc_latency", cyc, e.lat);
            chk("done", o_done, 1);
            chk("pc_out", o_pc_out, 32'(e.data));
            chk("mem_rd_cycles", rd, e.lat - 2);
            seen = 1'b1;
         end
      end
      chk("pc_write_seen", seen, 1);
      $display("[TB] seq dut=%s cause=%0d epc=0x%08h vec=0x%0h handler=0x%02h latency=%0d",
               sel ? "b" : "a", e.cause, e.epc, e.addr, e.data, e.lat);
   endtask

   // Confirms the sequencer stays quiet and cause_code stays sticky.
   task automatic idle_check(input int n, input int exp_cause);
      int events = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (o_epc_write || o_pc_write || o_busy || o_done) events++;
      end
      chk("extra_activity", events, 0);
      chk("cause_sticky", o_cause, exp_cause);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_addr"},  o_mem_addr, 0);
      chk({tag, "_mem_rd"},    o_mem_rd, 0);
      chk({tag, "_epc_out"},   o_epc_out, 0);
      chk({tag, "_epc_write"}, o_epc_write, 0);
      chk({tag, "_pc_out"},    o_pc_out, 0);
      chk({tag, "_pc_write"},  o_pc_write, 0);
      chk({tag, "_busy"},      o_busy, 0);
      chk({tag, "_done"},      o_done, 0);
      chk({tag, "_cause"},     o_cause, 0);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) step();
      check_zero("reset");
      reset = 1'b0;
      step();

      // Single cause-1 request
      request(3'b010, 32'h40);
      push(32'h3C, 32'd254, CAUSE_OVF, 8'h8C, 4, 0, 3'b000);
      monitor();
      idle_check(6, CAUSE_OVF);

      // All causes at once: cause 0 wins
      request(3'b111, 32'h100);
      push(32'hFC, 32'd253, CAUSE_OPCODE, 8'h55, 4, 0, 3'b000);
      monitor();
      last_cause = CAUSE_OPCODE;
`ifdef EXCP_NEST_EN
      push(32'h51, 32'd254, CAUSE_OVF, 8'h66, 4, 0, 3'b000);
      monitor();
      push(32'h62, 32'd255, CAUSE_DIV0, 8'h77, 4, 0, 3'b000);
      monitor();
      last_cause = CAUSE_DIV0;
`endif
      idle_check(6, last_cause);

      // MEM_WAIT = 5 instance, PC wrap at pc_in = 0
      sel = 1'b1;
      request(3'b100, 32'h0);
      push(32'hFFFF_FFFC, 32'd255, CAUSE_DIV0, 8'h12, 7, 0, 3'b000);
      monitor();
      idle_check(6, CAUSE_DIV0);
      sel = 1'b0;

      // Reset during WAIT aborts the sequence; requests ignored in reset
      request(3'b001, 32'h20);
      step();
      chk("abort_save_epc_write", o_epc_write, 1);
      step();
      chk("abort_wait_mem_rd", o_mem_rd, 1);
      reset = 1'b1;
      step();
      check_zero("abort");
      step();
      chk("abort_req_ignored_busy", o_busy, 0);
      reset = 1'b0;
      set_req(3'b000);
      idle_check(8, 0);

      // Request raised during WAIT of a cause-1 sequence
      request(3'b010, 32'h40);
      push(32'h3C, 32'd254, CAUSE_OVF, 8'h8C, 4, 2, 3'b100);
      monitor();
      last_cause = CAUSE_OVF;
`ifdef EXCP_NEST_EN
      push(32'h88, 32'd255, CAUSE_DIV0, 8'h30, 4, 0, 3'b000);
      monitor();
      last_cause = CAUSE_DIV0;
`endif
      idle_check(8, last_cause);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
